// File: rtl/mem_burst_master.sv
// Burst initiator for an 8-bit single-port memory: one access per clock, wrapping address.
// Define MEM_BURST_MASTER_WR_VERIFY_EN to read back and compare every written beat.
module mem_burst_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              vfy_err,
  output logic              mem_r_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_TAIL = 3'd3,
    ST_DONE    = 3'd4,
    ST_WR_CHK  = 3'd5,
    ST_WR_CMP  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]        beats_left_q, beats_left_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
`ifdef MEM_BURST_MASTER_WR_VERIFY_EN
  logic              vfy_err_q, vfy_err_d;
  logic [ADDR_W-1:0] sv_addr_q, sv_addr_d;
  logic [DATA_W-1:0] sv_data_q, sv_data_d;
  logic              last_q, last_d;
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits for ready, and ready is a pure function of the current state.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rd_valid_d   = (state_q == ST_RD);
    done_d       = 1'b0;
`ifdef MEM_BURST_MASTER_WR_VERIFY_EN
    vfy_err_d    = vfy_err_q;
    sv_addr_d    = sv_addr_q;
    sv_data_d    = sv_data_q;
    last_d       = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cur_addr_d   = cmd_addr;
          beats_left_d = cmd_len;
`ifdef MEM_BURST_MASTER_WR_VERIFY_EN
          vfy_err_d    = 1'b0;
`endif
          state_d      = cmd_rw ? ST_RD : ST_WR;
        end
      end
      ST_WR: begin
        if (wr_valid) begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          if (beats_left_q != 8'd0) beats_left_d = beats_left_q - 8'd1;
`ifdef MEM_BURST_MASTER_WR_VERIFY_EN
          sv_addr_d = cur_addr_q;
          sv_data_d = wr_data;
          last_d    = (beats_left_q == 8'd0);
          state_d   = ST_WR_CHK;
`else
          if (beats_left_q == 8'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
`endif
        end
      end
      ST_RD: begin
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        if (beats_left_q == 8'd0) state_d = ST_RD_TAIL;
        else beats_left_d = beats_left_q - 8'd1;
      end
      ST_RD_TAIL: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
`ifdef MEM_BURST_MASTER_WR_VERIFY_EN
      ST_WR_CHK: state_d = ST_WR_CMP;
      ST_WR_CMP: begin
        // mem_rdata now holds the registered read of the address issued in WR_CHK
        if (mem_rdata != sv_data_q) vfy_err_d = 1'b1;
        if (last_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_WR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= 8'd0;
      rd_valid_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef MEM_BURST_MASTER_WR_VERIFY_EN
      vfy_err_q    <= 1'b0;
      sv_addr_q    <= '0;
      sv_data_q    <= '0;
      last_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rd_valid_q   <= rd_valid_d;
      done_q       <= done_d;
`ifdef MEM_BURST_MASTER_WR_VERIFY_EN
      vfy_err_q    <= vfy_err_d;
      sv_addr_q    <= sv_addr_d;
      sv_data_q    <= sv_data_d;
      last_q       <= last_d;
`endif
    end
  end

  // Status outputs are masked during reset so a reset cycle never looks like activity.
  assign cmd_ready = ~rst & (state_q == ST_IDLE);
  assign busy      = ~rst & (state_q != ST_IDLE);
  assign wr_ready  = ~rst & (state_q == ST_WR);
  assign done      = ~rst & done_q;
  assign rd_valid  = ~rst & rd_valid_q;
  assign rd_data   = mem_rdata;
  assign mem_r_w   = ~(wr_ready & wr_valid);
  assign mem_wdata = wr_data;
`ifdef MEM_BURST_MASTER_WR_VERIFY_EN
  assign mem_addr  = ((state_q == ST_WR_CHK) || (state_q == ST_WR_CMP)) ? sv_addr_q : cur_addr_q;
  assign vfy_err   = ~rst & vfy_err_q;
`else
  assign mem_addr  = cur_addr_q;
  assign vfy_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a registered-read memory model and write scoreboard.
// Under MEM_BURST_MASTER_WR_VERIFY_EN the model corrupts writes to 0x05.
module tb_mem_burst_master;

`ifdef MEM_BURST_MASTER_WR_VERIFY_EN
  localparam int BEAT_CYC = 3;
`else
  localparam int BEAT_CYC = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [7:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy, done, vfy_err, mem_r_w;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  mem_burst_master #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .vfy_err(vfy_err),
    .mem_r_w(mem_r_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- memory model and monitors ----------------
  logic [7:0]  mem [256];
  logic [15:0] obs_q[$];
  int          wcyc_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  rdd_q[$];
  int          rdc_q[$];
  int          done_cnt = 0;

  always @(posedge clk) begin : mem_model
    logic [7:0] wv;
    mem_rdata <= mem[mem_addr];
    if (!mem_r_w) begin
      wv = mem_wdata;
`ifdef MEM_BURST_MASTER_WR_VERIFY_EN
      if (mem_addr == 8'h05) wv = wv ^ 8'hFF;
`endif
      mem[mem_addr] = wv;
      obs_q.push_back({mem_addr, mem_wdata});
      wcyc_q.push_back(cyc);
    end
  end

  always @(negedge clk) begin : scoreboard
    logic [15:0] w;
    while (obs_q.size() > 0) begin
      w = obs_q.pop_front();
      check_eq("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("wr_addr_data", 32'(w), 32'(exp_q.pop_front()));
    end
    if (rd_valid) begin
      rdd_q.push_back(rd_data);
      rdc_q.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic rw, input logic [7:0] addr, input logic [7:0] len,
                          output int t1);
    int n;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_len   = len;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    check_eq("cmd_ready_seen", 32'(cmd_ready), 32'd1);
    next_cycle();
    cmd_valid = 1'b0;
    t1 = cyc;
  endtask

  task automatic write_beat(input logic [7:0] d);
    int n;
    wr_valid = 1'b1;
    wr_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_ready && n < 50);
    check_eq("wr_ready_seen", 32'(wr_ready), 32'd1);
    next_cycle();
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 600);
    check_eq("done_seen", 32'(done), 32'd1);
    dc = cyc;
  endtask

  // ---------------- directed tests ----------------
  logic [7:0] pat [4];
  int t1, t1b, dc, base, n;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 8'h00; cmd_len = 8'h00;
    wr_valid = 1'b0; wr_data = 8'h00;
    pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_vfy_err", 32'(vfy_err), 32'd0);
    check_eq("rst_mem_r_w", 32'(mem_r_w), 32'd1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_mem_addr", 32'(mem_addr), 32'h00);
    next_cycle();

    // write len=3 at 0x10, wr_valid held high
    wcyc_q.delete();
    base = done_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(8'h10 + i), pat[i]});
    send_cmd(1'b0, 8'h10, 8'd3, t1);
    for (int i = 0; i < 4; i++) write_beat(pat[i]);
    wait_done(dc);
    check_eq("wr4_done_cyc", 32'(dc), 32'(t1 + 4 * BEAT_CYC));
    check_eq("wr4_vfy_err", 32'(vfy_err), 32'd0);
    @(negedge clk);
    check_eq("wr4_cmd_ready_after", 32'(cmd_ready), 32'd1);
    check_eq("wr4_busy_after", 32'(busy), 32'd0);
    check_eq("wr4_done_count", 32'(done_cnt - base), 32'd1);
    check_eq("wr4_write_count", 32'(wcyc_q.size()), 32'd4);
    for (int i = 0; i < wcyc_q.size(); i++)
      check_eq("wr4_write_cyc", 32'(wcyc_q[i]), 32'(t1 + BEAT_CYC * i));
    check_eq("wr4_exp_drained", 32'(exp_q.size()), 32'd0);
    next_cycle();

    // read len=3 at 0x10
    rdd_q.delete(); rdc_q.delete();
    base = done_cnt;
    send_cmd(1'b1, 8'h10, 8'd3, t1);
    wait_done(dc);
    check_eq("rd4_done_cyc", 32'(dc), 32'(t1 + 5));
    @(negedge clk);
    check_eq("rd4_done_count", 32'(done_cnt - base), 32'd1);
    check_eq("rd4_beat_count", 32'(rdd_q.size()), 32'd4);
    for (int i = 0; i < rdd_q.size() && i < 4; i++) begin
      check_eq("rd4_data", 32'(rdd_q[i]), 32'(pat[i]));
      check_eq("rd4_cyc", 32'(rdc_q[i]), 32'(t1 + 1 + i));
    end
    next_cycle();

    // write len=1 at 0xFF with a 2-cycle gap: address wraps to 0x00
    wcyc_q.delete();
    base = done_cnt;
    exp_q.push_back({8'hFF, 8'h5A});
    exp_q.push_back({8'h00, 8'h3C});
    send_cmd(1'b0, 8'hFF, 8'd1, t1);
    write_beat(8'h5A);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("gap_mem_r_w", 32'(mem_r_w), 32'd1);
      next_cycle();
    end
    write_beat(8'h3C);
    wait_done(dc);
    @(negedge clk);
    check_eq("wrap_write_count", 32'(wcyc_q.size()), 32'd2);
    if (wcyc_q.size() == 2) begin
      check_eq("wrap_gap_cyc", 32'(wcyc_q[1]), 32'(wcyc_q[0] + 3));
      check_eq("wrap_done_cyc", 32'(dc), 32'(wcyc_q[1] + BEAT_CYC));
    end
    check_eq("wrap_done_count", 32'(done_cnt - base), 32'd1);
    check_eq("wrap_exp_drained", 32'(exp_q.size()), 32'd0);
    next_cycle();

    // read len=0 at 0x42 (untouched: 0x42 ^ 0x5A = 0x18)
    rdd_q.delete(); rdc_q.delete();
    send_cmd(1'b1, 8'h42, 8'd0, t1);
    @(negedge clk);
    check_eq("rd1_first_addr", 32'(mem_addr), 32'h42);
    check_eq("rd1_first_r_w", 32'(mem_r_w), 32'd1);
    check_eq("rd1_busy", 32'(busy), 32'd1);
    wait_done(dc);
    check_eq("rd1_done_cyc", 32'(dc), 32'(t1 + 2));
    check_eq("rd1_beat_count", 32'(rdd_q.size()), 32'd1);
    if (rdd_q.size() == 1) begin
      check_eq("rd1_data", 32'(rdd_q[0]), 32'h18);
      check_eq("rd1_cyc", 32'(rdc_q[0]), 32'(t1 + 1));
    end
    next_cycle();

    // read 256 beats from 0x80: wraps through 0xFF -> 0x00
    rdd_q.delete(); rdc_q.delete();
    send_cmd(1'b1, 8'h80, 8'd255, t1);
    wait_done(dc);
    check_eq("rd256_done_cyc", 32'(dc), 32'(t1 + 257));
    check_eq("rd256_beat_count", 32'(rdd_q.size()), 32'd256);
    if (rdd_q.size() == 256) begin
      check_eq("rd256_first", 32'(rdd_q[0]), 32'hDA);
      check_eq("rd256_at_ff", 32'(rdd_q[127]), 32'h5A);
      check_eq("rd256_at_00", 32'(rdd_q[128]), 32'h3C);
      check_eq("rd256_last", 32'(rdd_q[255]), 32'h25);
      check_eq("rd256_last_cyc", 32'(rdc_q[255]), 32'(t1 + 256));
    end
    next_cycle();

    // reset during the second beat of a len=5 write at 0x20
    base = done_cnt;
    exp_q.push_back({8'h20, 8'h11});
    send_cmd(1'b0, 8'h20, 8'd5, t1);
    write_beat(8'h11);
    wr_valid = 1'b1;
    wr_data  = 8'h22;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_ready && n < 50);
    check_eq("rstmid_wr_ready", 32'(wr_ready), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("rstmid_mem_r_w", 32'(mem_r_w), 32'd1);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_wr_ready_low", 32'(wr_ready), 32'd0);
    next_cycle();
    rst = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    check_eq("rstmid_idle_busy", 32'(busy), 32'd0);
    check_eq("rstmid_idle_ready", 32'(cmd_ready), 32'd1);
    repeat (8) @(negedge clk);
    check_eq("rstmid_no_done", 32'(done_cnt - base), 32'd0);
    check_eq("rstmid_mem20", 32'(mem[8'h20]), 32'h11);
    check_eq("rstmid_mem21", 32'(mem[8'h21]), 32'h7B);
    check_eq("rstmid_exp_drained", 32'(exp_q.size()), 32'd0);
    next_cycle();

`ifdef MEM_BURST_MASTER_WR_VERIFY_EN
    // write-verify against a memory that corrupts 0x05
    wcyc_q.delete();
    exp_q.push_back({8'h04, 8'h44});
    exp_q.push_back({8'h05, 8'h55});
    exp_q.push_back({8'h06, 8'h66});
    send_cmd(1'b0, 8'h04, 8'd2, t1);
    write_beat(8'h44);
    repeat (3) @(negedge clk);
    check_eq("vfy_clean_beat", 32'(vfy_err), 32'd0);
    next_cycle();
    write_beat(8'h55);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vfy_err && n < 8);
    check_eq("vfy_set", 32'(vfy_err), 32'd1);
    if (wcyc_q.size() == 2) check_eq("vfy_set_cyc", 32'(cyc), 32'(wcyc_q[1] + 3));
    next_cycle();
    write_beat(8'h66);
    wait_done(dc);
    check_eq("vfy_at_done", 32'(vfy_err), 32'd1);
    if (wcyc_q.size() == 3) check_eq("vfy_done_cyc", 32'(dc), 32'(wcyc_q[2] + 3));
    @(negedge clk);
    check_eq("vfy_sticky_idle", 32'(vfy_err), 32'd1);
    next_cycle();
    rdd_q.delete(); rdc_q.delete();
    send_cmd(1'b1, 8'h05, 8'd0, t1b);
    @(negedge clk);
    check_eq("vfy_cleared", 32'(vfy_err), 32'd0);
    wait_done(dc);
    check_eq("vfy_rd_count", 32'(rdd_q.size()), 32'd1);
    if (rdd_q.size() == 1) check_eq("vfy_rd_corrupt", 32'(rdd_q[0]), 32'hAA);
    check_eq("vfy_exp_drained", 32'(exp_q.size()), 32'd0);
    next_cycle();
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
